// File: rtl/c8to512_packer_if.sv
// Byte-in / wide-word-out bus for the ingress packer.
// The slave side is the packer. The master side drives bytes and accepts words.
interface c8to512_packer_if #(
  parameter int DATA_WIDTH = 480,
  parameter int CTRL_WIDTH = 32
);
  logic [7:0]            in_data;
  logic                  in_wr;
  logic                  in_eop;
  logic                  in_rdy;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctl;
  logic                  out_wr;
  logic                  out_rdy;

  modport slave  (input  in_data, in_wr, in_eop, out_rdy,
                  output in_rdy, out_data, out_ctl, out_wr);
  modport master (output in_data, in_wr, in_eop, out_rdy,
                  input  in_rdy, out_data, out_ctl, out_wr);
endinterface

// File: rtl/c8to512_packer.sv
// Packs a byte stream into DATA_WIDTH-bit words, first byte in the MSB lane.
// A one-deep output slot and a pending word absorb downstream stalls.
module c8to512_packer #(
  parameter int DATA_WIDTH = 480,
  parameter int CTRL_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  c8to512_packer_if.slave    bus
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic [BYTES-1:0][7:0]  asm_q, merged;
  logic [7:0]             cnt_q;
  logic                   pend_q, sop_q;
  logic [15:0]            widx_q;
  logic [CTRL_WIDTH-1:0]  pend_ctl_q, out_ctl_q, ctl_w;
  logic [DATA_WIDTH-1:0]  out_data_q;
  logic                   out_wr_q;
  logic                   acc, slot_free, xfer, last;

  assign acc       = bus.in_wr && !pend_q;
  assign slot_free = !out_wr_q || bus.out_rdy;
  assign xfer      = out_wr_q && bus.out_rdy;
  assign last      = acc && ((cnt_q == 8'(BYTES-1)) || bus.in_eop);

  // Byte k lands in lane BYTES-1-k so the first byte sits at the top bits.
  for (genvar l = 0; l < BYTES; l++) begin : g_lane
    assign merged[l] = (acc && cnt_q == 8'(BYTES-1-l)) ? bus.in_data : asm_q[l];
  end

  always_comb begin
    ctl_w        = '0;
    ctl_w[7:0]   = cnt_q + 8'd1;
    ctl_w[8]     = sop_q;
    ctl_w[9]     = bus.in_eop;
    ctl_w[31:16] = widx_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_q      <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_ctl_q <= '0;
      sop_q      <= 1'b1;
      widx_q     <= '0;
      out_data_q <= '0;
      out_ctl_q  <= '0;
      out_wr_q   <= 1'b0;
    end else begin
      if (pend_q) begin
        // Input is stalled while pending, so no byte can collide here.
        if (slot_free) begin
          out_data_q <= asm_q;
          out_ctl_q  <= pend_ctl_q;
          out_wr_q   <= 1'b1;
          pend_q     <= 1'b0;
          asm_q      <= '0;
          cnt_q      <= '0;
        end
      end else if (last) begin
        sop_q  <= bus.in_eop;
        widx_q <= bus.in_eop ? 16'd0 : widx_q + 16'd1;
        if (slot_free) begin
          out_data_q <= merged;
          out_ctl_q  <= ctl_w;
          out_wr_q   <= 1'b1;
          asm_q      <= '0;
          cnt_q      <= '0;
        end else begin
          asm_q      <= merged;
          pend_ctl_q <= ctl_w;
          pend_q     <= 1'b1;
        end
      end else begin
        if (acc) begin
          asm_q <= merged;
          cnt_q <= cnt_q + 8'd1;
        end
        if (xfer) out_wr_q <= 1'b0;
      end
    end
  end

  assign bus.in_rdy   = !pend_q;
  assign bus.out_data = out_data_q;
  assign bus.out_ctl  = out_ctl_q;
  assign bus.out_wr   = out_wr_q;
endmodule

// File: tb/tb_c8to512_packer.sv
// Directed bench for c8to512_packer: reset, full/split/short packets, backpressure.
module tb_c8to512_packer;
  localparam int DW = 480;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  c8to512_packer_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) ifc ();
  c8to512_packer #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(ifc));

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] qd[$];
  logic [CW-1:0] qc[$];

  always @(negedge clk)
    if (rst && ifc.out_wr && ifc.out_rdy) begin
      qd.push_back(ifc.out_data);
      qc.push_back(ifc.out_ctl);
    end

  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkword(input int first, input int n);
    logic [DW-1:0] w;
    logic [7:0] b;
    w = '0;
    for (int k = 0; k < n; k++) begin
      b = 8'(first + k);
      w[DW-1-8*k -: 8] = b;
    end
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic e);
    logic ok;
    int n;
    n = 0;
    ifc.in_wr = 1'b1; ifc.in_data = b; ifc.in_eop = e;
    do begin
      @(negedge clk); ok = ifc.in_rdy;
      @(posedge clk); #1; n++;
    end while (!ok && n < 200);
    if (!ok) chk("send_timeout", {511'd0, ok}, 512'd1);
    ifc.in_wr = 1'b0; ifc.in_eop = 1'b0;
  endtask

  task automatic chk_word(input string tag, input int idx, input int first, input int n,
                          input logic [CW-1:0] ctl);
    chk({tag, "_data"}, {32'd0, qd[idx]}, {32'd0, mkword(first, n)});
    chk({tag, "_ctl"}, {480'd0, qc[idx]}, {480'd0, ctl});
  endtask

  initial begin
    ifc.in_data = '0; ifc.in_wr = 1'b0; ifc.in_eop = 1'b0; ifc.out_rdy = 1'b1;
    #12;
    chk("rst_out_wr", {511'd0, ifc.out_wr}, 512'd0);
    chk("rst_in_rdy", {511'd0, ifc.in_rdy}, 512'd1);
    chk("rst_out_data", {32'd0, ifc.out_data}, 512'd0);
    chk("rst_out_ctl", {480'd0, ifc.out_ctl}, 512'd0);
    @(posedge clk); #1; rst = 1'b1;
    idle(1);

    // Reset mid-packet: the partial word must vanish.
    for (int i = 0; i < 10; i++) send(8'(i + 1), 1'b0);
    rst = 1'b0;
    idle(2);
    chk("midrst_out_wr", {511'd0, ifc.out_wr}, 512'd0);
    rst = 1'b1;
    idle(1);
    qd.delete(); qc.delete();
    send(8'hAB, 1'b1);
    idle(3);
    chk("midrst_nwords", 512'(qd.size()), 512'd1);
    chk("midrst_data", {32'd0, qd[0]}, {32'd0, 8'hAB, 472'd0});
    chk("midrst_ctl", {480'd0, qc[0]}, 512'h0301);

    // Full 60-byte packet, eop on the filling byte.
    qd.delete(); qc.delete();
    for (int i = 0; i < 59; i++) send(8'(i), 1'b0);
    chk("full_wr_before", {511'd0, ifc.out_wr}, 512'd0);
    send(8'h3B, 1'b1);
    chk("full_latency", {511'd0, ifc.out_wr}, 512'd1);
    idle(3);
    chk("full_nwords", 512'(qd.size()), 512'd1);
    chk("full_lsb", {504'd0, qd[0][7:0]}, 512'h3B);
    chk_word("full", 0, 0, 60, 32'h0000_033C);

    // 130-byte packet splits into 60/60/10.
    qd.delete(); qc.delete();
    for (int i = 0; i < 130; i++) send(8'(i), i == 129);
    idle(3);
    chk("split_nwords", 512'(qd.size()), 512'd3);
    chk_word("split0", 0, 0, 60, 32'h0000_013C);
    chk_word("split1", 1, 60, 60, 32'h0001_003C);
    chk_word("split2", 2, 120, 10, 32'h0002_020A);

    // Backpressure: one word in the slot, one pending, then ignored writes.
    qd.delete(); qc.delete();
    ifc.out_rdy = 1'b0;
    for (int i = 0; i < 120; i++) send(8'(i), 1'b0);
    chk("bp_in_rdy", {511'd0, ifc.in_rdy}, 512'd0);
    chk("bp_out_wr", {511'd0, ifc.out_wr}, 512'd1);
    ifc.in_wr = 1'b1; ifc.in_data = 8'hFF;
    idle(4);
    chk("bp_hold_data", {32'd0, ifc.out_data}, {32'd0, mkword(0, 60)});
    chk("bp_hold_ctl", {480'd0, ifc.out_ctl}, 512'h013C);
    chk("bp_still_wr", {511'd0, ifc.out_wr}, 512'd1);
    chk("bp_still_blk", {511'd0, ifc.in_rdy}, 512'd0);
    ifc.in_wr = 1'b0;
    ifc.out_rdy = 1'b1;
    idle(1);
    chk("bp_rdy_back", {511'd0, ifc.in_rdy}, 512'd1);
    chk("bp_pend_ctl", {480'd0, ifc.out_ctl}, 512'h0001_003C);
    for (int i = 120; i < 180; i++) send(8'(i), i == 179);
    idle(3);
    chk("bp_nwords", 512'(qd.size()), 512'd3);
    chk_word("bp0", 0, 0, 60, 32'h0000_013C);
    chk_word("bp1", 1, 60, 60, 32'h0001_003C);
    chk_word("bp2", 2, 120, 60, 32'h0002_023C);

    // Back-to-back 1-byte packets keep out_wr high.
    qd.delete(); qc.delete();
    for (int i = 0; i < 8; i++) begin
      send(8'(8'hA0 + i), 1'b1);
      if (i > 0) chk("b2b_wr_high", {511'd0, ifc.out_wr}, 512'd1);
    end
    idle(1);
    chk("b2b_wr_drop", {511'd0, ifc.out_wr}, 512'd0);
    chk("b2b_nwords", 512'(qd.size()), 512'd8);
    for (int i = 0; i < 8; i++) chk_word("b2b", i, 8'hA0 + i, 1, 32'h0000_0301);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/c8to512_packer.md
Name: c8to512_packer

Overview:
- Byte-to-wide packer: accepts a byte stream (one byte per in_wr strobe) and assembles it into DATA_WIDTH-bit data words with a CTRL_WIDTH-bit control word.
- Sits on the ingress side of the pipeline, feeding the wide stage datapath. It is the converse of the wide-to-byte egress converter.
- A word is emitted when it is full or when the packet's last byte arrives.
- A one-deep output holding slot with a ready/valid handshake absorbs downstream stalls.

Parameters:
- DATA_WIDTH, 480: output data width; must be a multiple of 8. BYTES = DATA_WIDTH/8 = 60.
- CTRL_WIDTH, 32: output control width; fixed field layout below, minimum 32.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  8  input byte.
- in_wr  in  1  byte strobe; the byte is accepted when in_wr && in_rdy.
- in_eop  in  1  qualifies in_wr; marks the last byte of a packet.
- in_rdy  out  1  packer can accept a byte this cycle.
- out_data  out  DATA_WIDTH  assembled word, first byte in [DATA_WIDTH-1:DATA_WIDTH-8].
- out_ctl  out  CTRL_WIDTH  word metadata.
- out_wr  out  1  out_data/out_ctl valid.
- out_rdy  in  1  downstream accepts the word; transfer occurs when out_wr && out_rdy.

Behaviour:
- Reset (rst=0, async): out_data=0, out_ctl=0, out_wr=0, in_rdy=1, byte count=0, assembly register=0, pend=0, sop flag=1, word index=0. A partial word in flight is discarded. Operation resumes on the first clk edge after rst=1.
- Assembly: byte k of a word (k=0..BYTES-1) goes to bits [DATA_WIDTH-1-8k : DATA_WIDTH-8-8k]. Unused lanes of a short word are 0.
- The word completes on an accepted byte when byte count==BYTES-1 or when in_eop=1.
- Output slot is free when out_wr==0, or when out_wr&&out_rdy in the same cycle.
- On completion with the slot free:
  - The merged word, including the current byte, loads into out_data/out_ctl at that edge, and out_wr=1 from the next cycle (latency 1 clk from the last byte).
  - The assembly register clears and the byte count resets to 0.
- On completion with the slot busy:
  - The word is held in the assembly register and pend=1.
  - in_rdy=0 while pend=1.
  - On the first cycle the slot is free, the word moves to the output registers and pend clears. in_rdy returns to 1 the cycle after the transfer edge.
- in_rdy = !pend (registered). in_wr while in_rdy=0 is ignored, with no state change; upstream must hold.
- out_wr stays high with out_data/out_ctl stable until out_rdy=1.
  - After a transfer edge, out_wr=0 unless a new word loads on the same edge. Back-to-back words keep out_wr=1.
- out_ctl fields:
  - [7:0] valid byte count, 1..BYTES.
  - [8] sop: first word of the packet.
  - [9] eop: word contains the last byte.
  - [15:10] 0.
  - [31:16] word index within the packet: 0 for the sop word, incrementing per emitted word, wrapping at 65535→0. It resets to 0 after an eop word.
  - Bits above 31 are 0.
- in_eop on the byte that also fills the word: a single word with count=BYTES and eop=1; no empty extra word.
- A 1-byte packet gives a word with count=1, sop=1, eop=1.
- A packet longer than BYTES is split; middle words have sop=0, eop=0, count=BYTES.
- No bytes are lost or duplicated under any out_rdy pattern.

Test Plan:
- Reset mid-packet:
  - Stimulus: 10 bytes in, then rst=0 for 2 cycles, then a 1-byte packet 0xAB with eop.
  - Required: out_wr=0 during reset, and the first word after reset has out_data[479:472]=0xAB, remaining bits 0, out_ctl=0x0000_0301.
- Full word:
  - Stimulus: 60 bytes 0x00..0x3B, eop on the last, out_rdy=1.
  - Required: out_wr=1 one cycle after the last byte, out_data[479:472]=0x00, out_data[7:0]=0x3B, out_ctl=0x0000_033C, one word only.
- Split packet:
  - Stimulus: 130 bytes with eop on the last, out_rdy=1.
  - Required: 3 words with ctl 0x0000_013C, 0x0001_003C, 0x0002_020A. The third word holds 10 valid bytes and 400 zero bits.
- Backpressure:
  - Stimulus: out_rdy=0, stream 180 bytes continuously.
  - Required: after 120 bytes accepted, in_rdy=0 and out_wr stays stable.
  - Then raise out_rdy: words drain in order with no byte loss, and in_rdy returns to 1 one cycle after the pending transfer.
- Back-to-back short packets:
  - Stimulus: 1-byte eop packets every cycle, with out_rdy=1.
  - Required: out_wr stays high continuously, each ctl=0x0000_0301, and the data bytes match in order.
- Ignored write:
  - Stimulus: in_wr=1 while in_rdy=0 with byte 0xFF.
  - Required: 0xFF never appears in any output word, and the byte count is unchanged.
